// File: rtl/i2c_codec_slave.sv
// Write-only I2C target for codec control frames (7-bit register, 9-bit data in 3 bytes).
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchronisers.
`timescale 1ns/1ps
module i2c_codec_slave #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [6:0] wr_reg,
  output logic [8:0] wr_data,
  output logic       busy,
  output logic [2:0] err_code
);
  typedef enum logic [2:0] {IDLE, ADDR, ACK0, BYTE1, ACK1, BYTE2, ACK2, IGNORE} state_t;

  localparam logic [2:0] ERR_OK    = 3'd0;
  localparam logic [2:0] ERR_ADDR  = 3'd1;
  localparam logic [2:0] ERR_READ  = 3'd2;
  localparam logic [2:0] ERR_TRUNC = 3'd3;
  localparam logic [2:0] ERR_OVR   = 3'd4;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_y, sda_y, scl_s, sda_s, scl_p, sda_p;
  logic [2:0]             bit_cnt;
  logic [6:0]             shreg;
  logic [7:0]             byte1, byte_in;
  logic                   ovr_arm, ovr_bit;
  logic                   scl_rise, scl_fall, start_det, stop_det, byte_done, mid_frame;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_y = scl_sync[SYNC_STAGES-1];
  assign sda_y = sda_sync[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] scl_hist, sda_hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hist <= '1;
      sda_hist <= '1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_y};
      sda_hist <= {sda_hist[1:0], sda_y};
    end
  end

  assign scl_s = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) | (scl_hist[1] & scl_hist[2]);
  assign sda_s = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) | (sda_hist[1] & sda_hist[2]);
`else
  assign scl_s = scl_y;
  assign sda_s = sda_y;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_s;
      sda_p <= sda_s;
    end
  end

  // START/STOP need SCL high on both samples, so an SDA move coincident with SCL falling is data
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_p & scl_s & sda_p & ~sda_s;
  assign stop_det  = scl_p & scl_s & ~sda_p & sda_s;
  assign byte_done = scl_rise && (bit_cnt == 3'd7);
  assign byte_in   = {shreg, sda_s};
  assign mid_frame = state inside {ADDR, ACK0, BYTE1, ACK1, BYTE2};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_reg   <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      err_code <= ERR_OK;
      bit_cnt  <= '0;
      shreg    <= '0;
      byte1    <= '0;
      ovr_arm  <= 1'b0;
      ovr_bit  <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      if (start_det) begin
        state    <= ADDR;
        busy     <= 1'b1;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        ovr_arm  <= 1'b0;
        ovr_bit  <= 1'b0;
        err_code <= mid_frame ? ERR_TRUNC : ERR_OK;
      end else if (stop_det) begin
        state   <= IDLE;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
        ovr_arm <= 1'b0;
        ovr_bit <= 1'b0;
        if (mid_frame) err_code <= ERR_TRUNC;
      end else begin
        if (scl_rise) begin
          shreg   <= {shreg[5:0], sda_s};
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          IDLE: ;
          ADDR:
            if (byte_done) begin
              if (byte_in[7:1] != DEV_ADDR) begin
                state    <= IGNORE;
                err_code <= ERR_ADDR;
              end else if (byte_in[0]) begin
                state    <= IGNORE;
                err_code <= ERR_READ;
              end else begin
                state <= ACK0;
              end
            end
          BYTE1:
            if (byte_done) begin
              byte1 <= byte_in;
              state <= ACK1;
            end
          BYTE2:
            if (byte_done) begin
              wr_reg   <= byte1[7:1];
              wr_data  <= {byte1[0], byte_in};
              wr_valid <= 1'b1;
              state    <= ACK2;
            end
          ACK0, ACK1, ACK2:
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                ovr_arm <= (state == ACK2);
                state   <= (state == ACK0) ? BYTE1 : (state == ACK1) ? BYTE2 : IGNORE;
              end
            end
          IGNORE: begin
            // overrun is flagged on the falling edge so a STOP's SCL rise is not taken as a data bit
            if (scl_rise && ovr_arm) ovr_bit <= 1'b1;
            if (scl_fall && ovr_bit) begin
              err_code <= ERR_OVR;
              ovr_bit  <= 1'b0;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: doc/i2c_codec_slave.md
Name: i2c_codec_slave

Overview:
Write-only I2C target that receives the codec control frames our I2C master sends: a 7-bit register address plus 9-bit data, packed as 3 bytes.
- Samples SCL/SDA on the system clock, detects START/STOP and shifts bytes in.
- ACKs frames addressed to DEV_ADDR and issues a one-cycle register-write strobe.
- Used as a codec register model in simulation and as an on-FPGA control target.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address that is ACKed.
- SYNC_STAGES, 2, flops in the SCL/SDA input synchronisers (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- scl_in  in  1  I2C clock from the pad
- sda_in  in  1  I2C data from the pad
- sda_oe  out  1  1 = pull SDA low (open-drain); pad logic drives 'z' when 0
- wr_valid  out  1  one-cycle strobe: frame accepted
- wr_reg  out  7  register address; valid while wr_valid=1, then held
- wr_data  out  9  register data; valid while wr_valid=1, then held
- busy  out  1  high from START until STOP or abort
- err_code  out  3  result of the last frame, held until the next START

Behaviour:
- Reset (rst=0, async): state IDLE, sda_oe=0, wr_valid=0, wr_reg=0, wr_data=0, busy=0, err_code=0. Synchronisers reset to 1. Reset mid-frame releases SDA immediately.
- Sync: SCL and SDA each pass through SYNC_STAGES flops; the previous synced values are kept for edge detection.
- START: synced SDA 1->0 while SCL was 1 and is still 1.
- STOP: synced SDA 0->1 while SCL was 1 and is still 1.
- An SDA change in the same cycle SCL falls is data, not START/STOP.
- Data bits: sampled on the synced SCL rising edge, MSB first.
- Byte 0 = addr[6:0], rw. Byte 1 = reg[6:0], data[8]. Byte 2 = data[7:0].
- States: IDLE, ADDR, ACK0, BYTE1, ACK1, BYTE2, ACK2, IGNORE.
- IDLE: START -> ADDR; busy=1; bit counter=0; err_code=0.
- ADDR: after the 8th rising edge, check the byte.
  - addr==DEV_ADDR and rw=0 -> ACK0.
  - addr mismatch -> IGNORE, err_code=1.
  - rw=1 -> IGNORE, err_code=2.
- ACK phase (ACK0/ACK1/ACK2):
  - sda_oe goes 1 on the SCL falling edge after bit 8.
  - sda_oe goes 0 on the next SCL falling edge (end of the 9th clock).
  - Then go to the next state: ACK0->BYTE1, ACK1->BYTE2, ACK2->IGNORE.
- BYTE2: on the 8th rising edge, register wr_reg and wr_data. wr_valid=1 for exactly one clk cycle, 1 cycle after that edge. Then ACK2.
- IGNORE: never drives SDA.
  - Each further SCL rising edge after ACK2 sets err_code=4 (overrun, not ACKed).
  - Leaves only on STOP (-> IDLE, busy=0) or START (-> ADDR).
- Repeated START in any non-IDLE state: abort to ADDR, release SDA, counter=0. No wr_valid. err_code=3 if it arrives before BYTE2 completes.
- STOP before BYTE2 completes: IDLE, busy=0, err_code=3, no wr_valid.
- err_code values: 0 ok/none, 1 address mismatch, 2 read requested, 3 truncated, 4 overrun. Later errors overwrite earlier ones.
- The block never stretches SCL.
- SCL high and low times must each be >= SYNC_STAGES+2 clk cycles; faster SCL is unsupported.

Optional Feature:
- Macro: I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: after the synchronisers, SCL and SDA each pass a 3-sample majority filter. One-cycle glitches are rejected. Input-to-edge latency grows by 2 clk cycles; the minimum SCL phase rises to SYNC_STAGES+4 cycles.
- Undefined: synced signals are used directly.

Test Plan:
- Write frame: addr 0x1A w, byte1 0x1E, byte2 0x00, SCL half-period 200 clk -> three ACKs (sda_oe low across each 9th clock); one wr_valid pulse with wr_reg=0x0F, wr_data=0x000; err_code=0; busy drops after STOP.
- Write frame: reg 0x04, data 0x1F5 (byte1 0x09, byte2 0xF5) -> wr_reg=0x04, wr_data=0x1F5, exactly one wr_valid cycle.
- Address mismatch: addr 0x1B -> sda_oe stays 0 for the whole frame, no wr_valid, err_code=1. Read bit (0x35) -> err_code=2.
- STOP after byte1, then a full valid frame -> err_code=3 after the first; the second frame yields one wr_valid and err_code=0.
- Four data bytes -> only the first 2 are ACKed, one wr_valid, err_code=4. Repeated START mid-byte1 then a valid frame -> one wr_valid from the second frame only.
- rst asserted while sda_oe=1 during ACK0 -> sda_oe=0 and all outputs at reset values the same cycle. With I2C_SLAVE_GLITCH_FILTER_EN, a 1-clk SCL low glitch mid-bit causes no extra bit.
